mem_copy: RTL and testbench
===========================

MEM_COPY -- requirements
Module: mem_copy

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the attached RAM (4096 words).
REQ-002 Parameter DATA_W, default 16, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 start  input  1  copy request; sampled only in IDLE.
REQ-006 src  input  ADDR_W  first source word address; captured on accepted start.
REQ-007 dst  input  ADDR_W  first destination word address; captured on accepted start.
REQ-008 len  input  ADDR_W+1  word count, 0..4096; values >4096 treated as 4096.
REQ-009 mem_address  output  ADDR_W  address to RAM port.
REQ-010 mem_in  output  DATA_W  write data to RAM port.
REQ-011 mem_load  output  1  RAM write enable.
REQ-012 mem_out  input  DATA_W  RAM read data (asynchronous read, valid same cycle as mem_address).
REQ-013 busy  output  1  high in READ and WRITE states.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE, READ, WRITE, DONE; encoding free.
REQ-016 IDLE: mem_load=0, mem_address=0, mem_in=0, busy=0, done=0.
REQ-017 IDLE with start=1 and effective len>0 at edge: capture src_ptr<=src, dst_ptr<=dst, count<=len (clamped), go READ.
REQ-018 IDLE with start=1 and len=0 at edge: go DONE; no RAM write occurs.
REQ-019 READ: mem_address=src_ptr, mem_load=0; at edge data_reg<=mem_out, go WRITE.
REQ-020 WRITE: mem_address=dst_ptr, mem_in=data_reg, mem_load=1; at edge src_ptr and dst_ptr increment by 1 modulo 2^ADDR_W, count decrements.
REQ-021 WRITE exit: count==1 at edge -> DONE; else -> READ.
REQ-022 DONE: done=1, busy=0, mem_load=0 for exactly one cycle; then IDLE unconditionally.
REQ-023 Latency: for len=N>0, start accepted at edge E0; done high in cycle after edge E0+2N; N write cycles total.
REQ-024 Words copied in ascending address order; overlapping regions with dst in (src, src+N) SHALL propagate already-copied data (forward copy, no overlap correction).
REQ-025 Pointer wrap: address 4095 SHALL be followed by 0 for both src_ptr and dst_ptr.
REQ-026 start while busy or in DONE SHALL be ignored; src/dst/len changes during a copy SHALL have no effect.
REQ-027 mem_load SHALL never be asserted outside WRITE.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, clear src_ptr, dst_ptr, count, data_reg to 0, regardless of state; reset has priority over start.
REQ-029 Reset mid-copy: mem_load=0 from the cycle after the reset edge; words already written remain, no done pulse issued.
REQ-030 After reset: busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.

Verification
REQ-031 RAM preloaded mem[i]=i+0x100 for i=0..7; start src=0 dst=100 len=8 -> mem[100..107]=0x100..0x107, done pulse exactly 17 cycles after start edge, busy high 16 cycles.
REQ-032 len=0, start -> done high next cycle, mem_load never asserted, RAM unchanged.
REQ-033 src=4094 dst=10 len=4 with mem[4094]=0xAAAA, mem[4095]=0xBBBB, mem[0]=0xCCCC, mem[1]=0xDDDD -> mem[10..13]=AAAA,BBBB,CCCC,DDDD; also dst=4095 len=2 writes mem[4095], mem[0].
REQ-034 Overlap: mem[0..3]=1,2,3,4, src=0 dst=1 len=3 -> mem[0..3]=1,1,1,1.
REQ-035 Reset asserted in 3rd WRITE cycle of len=8 copy -> exactly 2 (or 3 if write edge coincides, per REQ-028 reset priority: 2) destination words changed, busy=0 next cycle, no done.
REQ-036 start pulsed during active copy with different src/dst -> ignored; original copy completes unchanged, single done pulse.

Source files
------------

// File: rtl/mem_copy.sv
// Word-by-word RAM-to-RAM copy engine driving a single-port RAM with asynchronous read.
// Each word takes one READ cycle and one WRITE cycle, in ascending address order.
module mem_copy #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W:0]   len_eff;

    assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (len_eff == '0) ? DONE : READ;
            READ:  state_next = WRITE;
            WRITE: state_next = (count == ONE) ? DONE : READ;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_address = '0;
        mem_in      = '0;
        mem_load    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            READ: begin
                mem_address = src_ptr;
                busy        = 1'b1;
            end
            WRITE: begin
                mem_address = dst_ptr;
                mem_in      = data_reg;
                // Reset wins over a coinciding write edge, so the RAM never sees that write.
                mem_load    = ~reset;
                busy        = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && len_eff != '0) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        count   <= len_eff;
                    end
                end
                READ: data_reg <= mem_out;
                WRITE: begin
                    src_ptr <= src_ptr + 1'b1;
                    dst_ptr <= dst_ptr + 1'b1;
                    count   <= count - ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy.sv
// Directed self-checking bench for mem_copy against a behavioural 4096x16 RAM.
// Expected RAM contents and timings are hand-computed per scenario.
module tb_mem_copy;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] src, dst;
    logic [12:0] len;
    logic [11:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        busy, done;

    logic [15:0] ram [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          wr_total = 0;
    int          done_total = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_copy #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load),
        .mem_out(mem_out), .busy(busy), .done(done)
    );

    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        if (mem_load) begin
            ram[mem_address] <= mem_in;
            wr_total <= wr_total + 1;
        end else if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the following negedge.
    task automatic poke(input int a, input logic [15:0] d);
        pl_we   = 1'b1;
        pl_addr = 12'(a);
        pl_data = d;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Issues a copy at a negedge; k counts negedges after the accepting edge.
    // Optionally re-pulses start with other operands at k == inj_k.
    task automatic run_copy(input int s, input int d, input int l, input int inj_k,
                            output int done_k, output int busy_cyc);
        done_k   = 0;
        busy_cyc = 0;
        src = 12'(s); dst = 12'(d); len = 13'(l); start = 1'b1;
        for (int k = 1; k <= 10000 && done_k == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            src = '0; dst = '0; len = '0;
            if (k == inj_k) begin
                start = 1'b1; src = 12'd0; dst = 12'd500; len = 13'd2;
            end
            if (busy) busy_cyc++;
            if (done) done_k = k;
        end
        if (done_k == 0) expect_eq("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        expect_eq("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    int done_k, busy_cyc, w0, d0;

    initial begin
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) @(negedge clk);
        expect_eq("rst_busy", {31'd0, busy}, 32'd0);
        expect_eq("rst_done", {31'd0, done}, 32'd0);
        expect_eq("rst_load", {31'd0, mem_load}, 32'd0);
        expect_eq("rst_addr", {20'd0, mem_address}, 32'd0);
        expect_eq("rst_din", {16'd0, mem_in}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic copy 0..7 -> 100..107
        for (int i = 0; i < 8; i++) poke(i, 16'(16'h100 + i));
        for (int i = 0; i < 8; i++) poke(100 + i, 16'h0);
        w0 = wr_total; d0 = done_total;
        run_copy(0, 100, 8, 0, done_k, busy_cyc);
        expect_eq("basic_latency", done_k, 17);
        expect_eq("basic_busy", busy_cyc, 16);
        expect_eq("basic_writes", wr_total - w0, 8);
        expect_eq("basic_dones", done_total - d0, 1);
        for (int i = 0; i < 8; i++) expect_eq("basic_data", {16'd0, ram[100 + i]}, 32'h100 + i);

        // Zero length
        poke(200, 16'h0);
        w0 = wr_total;
        run_copy(5, 200, 0, 0, done_k, busy_cyc);
        expect_eq("zero_latency", done_k, 1);
        expect_eq("zero_busy", busy_cyc, 0);
        expect_eq("zero_writes", wr_total - w0, 0);
        expect_eq("zero_ram", {16'd0, ram[200]}, 32'd0);

        // Source wrap
        poke(4094, 16'hAAAA); poke(4095, 16'hBBBB); poke(0, 16'hCCCC); poke(1, 16'hDDDD);
        run_copy(4094, 10, 4, 0, done_k, busy_cyc);
        expect_eq("wrap_src_latency", done_k, 9);
        expect_eq("wrap_src_10", {16'd0, ram[10]}, 32'hAAAA);
        expect_eq("wrap_src_11", {16'd0, ram[11]}, 32'hBBBB);
        expect_eq("wrap_src_12", {16'd0, ram[12]}, 32'hCCCC);
        expect_eq("wrap_src_13", {16'd0, ram[13]}, 32'hDDDD);

        // Destination wrap
        poke(20, 16'h1234); poke(21, 16'h5678);
        run_copy(20, 4095, 2, 0, done_k, busy_cyc);
        expect_eq("wrap_dst_4095", {16'd0, ram[4095]}, 32'h1234);
        expect_eq("wrap_dst_0", {16'd0, ram[0]}, 32'h5678);

        // Forward overlap propagates the first word
        poke(0, 16'd1); poke(1, 16'd2); poke(2, 16'd3); poke(3, 16'd4);
        run_copy(0, 1, 3, 0, done_k, busy_cyc);
        for (int i = 0; i < 4; i++) expect_eq("overlap", {16'd0, ram[i]}, 32'd1);

        // Reset during the third WRITE cycle
        for (int i = 0; i < 8; i++) poke(50 + i, 16'(16'h500 + i));
        for (int i = 0; i < 8; i++) poke(300 + i, 16'h0);
        w0 = wr_total; d0 = done_total;
        src = 12'd50; dst = 12'd300; len = 13'd8; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        expect_eq("rstmid_in_write", {31'd0, mem_load}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expect_eq("rstmid_busy", {31'd0, busy}, 32'd0);
        expect_eq("rstmid_load", {31'd0, mem_load}, 32'd0);
        repeat (20) @(negedge clk);
        expect_eq("rstmid_writes", wr_total - w0, 2);
        expect_eq("rstmid_no_done", done_total - d0, 0);
        expect_eq("rstmid_300", {16'd0, ram[300]}, 32'h500);
        expect_eq("rstmid_301", {16'd0, ram[301]}, 32'h501);
        expect_eq("rstmid_302", {16'd0, ram[302]}, 32'h0);

        // start re-pulsed mid-copy is ignored
        for (int i = 0; i < 4; i++) poke(60 + i, 16'(16'h600 + i));
        poke(500, 16'h0); poke(501, 16'h0);
        w0 = wr_total; d0 = done_total;
        run_copy(60, 400, 4, 3, done_k, busy_cyc);
        expect_eq("ign_latency", done_k, 9);
        expect_eq("ign_writes", wr_total - w0, 4);
        expect_eq("ign_dones", done_total - d0, 1);
        for (int i = 0; i < 4; i++) expect_eq("ign_data", {16'd0, ram[400 + i]}, 32'h600 + i);
        expect_eq("ign_500", {16'd0, ram[500]}, 32'd0);
        expect_eq("ign_501", {16'd0, ram[501]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
